// File: rtl/icache_fill_controller.sv
// Instruction-cache miss/fill sequencer: lookup, fault reporting, daisy-chain
// bus arbitration, multi-beat line fill and optional next-line prefetch.
module icache_fill_controller #(
    parameter int BEATS    = 4,
    parameter int BEAT_W   = 2,
    parameter bit PREFETCH = 1'b0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              read_valid_i,
    output logic              read_ready_o,
    output logic              dp_valid_o,
    input  logic              dp_ready_i,
    output logic              resp_fault_o,
    input  logic              tlb_hit_i,
    input  logic              cache_hit_i,
    input  logic              next_line_hit_i,
    input  logic              next_tlb_hit_i,
    output logic              write_o,
    output logic [BEAT_W-1:0] write_num_o,
    output logic              write_num_src_o,
    output logic              pa_src_o,
    output logic              pa_wr_en_o,
    output logic              req_addr_en_o,
    output logic              mem_req_o,
    input  logic              mem_ready_i,
    input  logic              bus_grant_i,
    output logic              grant_pass_o,
    input  logic              bus_busy_i,
    output logic              busy_out_o
);
    // state   | meaning
    // IDLE    | waiting for a fetch request
    // LOOKUP  | TLB/tag result available for the captured PA
    // ARB     | waiting for daisy-chain grant with the bus free
    // FILL    | bus owned, collecting BEATS beats into the arrays
    // RESP    | hit data or fault presented to fetch
    // PF_ADDR | loading PA+line for the next-line prefetch
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_ARB     = 3'd2;
    localparam logic [2:0] S_FILL    = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;
    localparam logic [2:0] S_PF_ADDR = 3'd5;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [2:0]        state_q, state_d;
    logic              pf_q, pf_d;
    logic              fault_q, fault_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pf_q    <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pf_q    <= pf_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pf_d    = pf_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (read_valid_i) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (!tlb_hit_i) begin
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end else if (cache_hit_i) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = '0;
                    pf_d    = 1'b0;
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (bus_grant_i && !bus_busy_i) state_d = S_FILL;
            end
            S_FILL: begin
                if (mem_ready_i) begin
                    cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + BEAT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = pf_q ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                if (dp_ready_i) begin
                    fault_d = 1'b0;
                    // prefetch only after a clean demand response whose next line misses but translates
                    if (PREFETCH && !fault_q && !next_line_hit_i && next_tlb_hit_i)
                        state_d = S_PF_ADDR;
                    else
                        state_d = S_IDLE;
                end
            end
            S_PF_ADDR: begin
                pf_d    = 1'b1;
                cnt_d   = '0;
                state_d = S_ARB;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        read_ready_o    = 1'b0;
        dp_valid_o      = 1'b0;
        resp_fault_o    = 1'b0;
        write_o         = 1'b0;
        write_num_o     = '0;
        write_num_src_o = 1'b0;
        pa_src_o        = 1'b0;
        pa_wr_en_o      = 1'b0;
        req_addr_en_o   = 1'b0;
        mem_req_o       = 1'b0;
        grant_pass_o    = 1'b0;
        busy_out_o      = 1'b0;
        if (!reset_i) begin
            case (state_q)
                S_IDLE: begin
                    read_ready_o = 1'b1;
                    pa_wr_en_o   = read_valid_i;
                    grant_pass_o = bus_grant_i;
                end
                S_LOOKUP: grant_pass_o = bus_grant_i;
                S_ARB: begin
                    req_addr_en_o = bus_grant_i & ~bus_busy_i;
                    grant_pass_o  = bus_grant_i & bus_busy_i;
                end
                S_FILL: begin
                    busy_out_o      = 1'b1;
                    mem_req_o       = 1'b1;
                    write_num_src_o = 1'b1;
                    write_num_o     = cnt_q;
                    write_o         = mem_ready_i;
                end
                S_RESP: begin
                    dp_valid_o   = 1'b1;
                    resp_fault_o = fault_q;
                    grant_pass_o = bus_grant_i;
                end
                S_PF_ADDR: begin
                    pa_wr_en_o   = 1'b1;
                    pa_src_o     = 1'b1;
                    grant_pass_o = bus_grant_i;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_fill_controller.sv
// Bench for icache_fill_controller: default instance (BEATS=4) plus a
// prefetching instance (BEATS=8), sharing stimulus, checked by scoreboards.
module tb_icache_fill_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, read_valid, dp_ready, tlb_hit, cache_hit, next_line_hit, next_tlb_hit;
    logic mem_ready, bus_grant, bus_busy;

    logic d_read_ready, d_dp_valid, d_resp_fault, d_write, d_write_num_src, d_pa_src;
    logic d_pa_wr_en, d_req_addr_en, d_mem_req, d_grant_pass, d_busy_out;
    logic [1:0] d_write_num;
    logic p_read_ready, p_dp_valid, p_resp_fault, p_write, p_write_num_src, p_pa_src;
    logic p_pa_wr_en, p_req_addr_en, p_mem_req, p_grant_pass, p_busy_out;
    logic [2:0] p_write_num;

    logic [12:0] d_outs, p_outs;
    assign d_outs = {d_read_ready, d_dp_valid, d_resp_fault, d_write, d_write_num, d_write_num_src,
                     d_pa_src, d_pa_wr_en, d_req_addr_en, d_mem_req, d_grant_pass, d_busy_out};
    assign p_outs = {p_read_ready, p_dp_valid, p_resp_fault, p_write, p_write_num[1:0], p_write_num_src,
                     p_pa_src, p_pa_wr_en, p_req_addr_en, p_mem_req, p_grant_pass, p_busy_out | p_write_num[2]};

    icache_fill_controller dut (
        .clk_i(clk), .reset_i(reset), .read_valid_i(read_valid), .read_ready_o(d_read_ready),
        .dp_valid_o(d_dp_valid), .dp_ready_i(dp_ready), .resp_fault_o(d_resp_fault),
        .tlb_hit_i(tlb_hit), .cache_hit_i(cache_hit), .next_line_hit_i(next_line_hit),
        .next_tlb_hit_i(next_tlb_hit), .write_o(d_write), .write_num_o(d_write_num),
        .write_num_src_o(d_write_num_src), .pa_src_o(d_pa_src), .pa_wr_en_o(d_pa_wr_en),
        .req_addr_en_o(d_req_addr_en), .mem_req_o(d_mem_req), .mem_ready_i(mem_ready),
        .bus_grant_i(bus_grant), .grant_pass_o(d_grant_pass), .bus_busy_i(bus_busy),
        .busy_out_o(d_busy_out)
    );

    icache_fill_controller #(.BEATS(8), .BEAT_W(3), .PREFETCH(1'b1)) dut_pf (
        .clk_i(clk), .reset_i(reset), .read_valid_i(read_valid), .read_ready_o(p_read_ready),
        .dp_valid_o(p_dp_valid), .dp_ready_i(dp_ready), .resp_fault_o(p_resp_fault),
        .tlb_hit_i(tlb_hit), .cache_hit_i(cache_hit), .next_line_hit_i(next_line_hit),
        .next_tlb_hit_i(next_tlb_hit), .write_o(p_write), .write_num_o(p_write_num),
        .write_num_src_o(p_write_num_src), .pa_src_o(p_pa_src), .pa_wr_en_o(p_pa_wr_en),
        .req_addr_en_o(p_req_addr_en), .mem_req_o(p_mem_req), .mem_ready_i(mem_ready),
        .bus_grant_i(bus_grant), .grant_pass_o(p_grant_pass), .bus_busy_i(bus_busy),
        .busy_out_o(p_busy_out)
    );

    int checks = 0;
    int failures = 0;
    logic       exp_fault_q[$];
    logic [2:0] exp_wn_q[$];

    task automatic clear_inputs();
        read_valid = 0; dp_ready = 0; tlb_hit = 0; cache_hit = 0; next_line_hit = 0;
        next_tlb_hit = 0; mem_ready = 0; bus_grant = 0; bus_busy = 0;
    endtask

    task automatic test_reset();
        reset = 1; read_valid = 1; bus_grant = 1; mem_ready = 1; dp_ready = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (d_outs !== '0) begin failures++; $display("FAIL reset_outs_d cyc=%0d got=%b exp=0", c, d_outs); end
            checks++;
            if (p_outs !== '0) begin failures++; $display("FAIL reset_outs_pf cyc=%0d got=%b exp=0", c, p_outs); end
            @(negedge clk);
        end
        reset = 0; clear_inputs();
        #1;
        checks++;
        if (d_read_ready !== 1'b1) begin failures++; $display("FAIL reset_release_rr got=%b exp=1", d_read_ready); end
        checks++;
        if ({d_dp_valid, d_mem_req, d_busy_out} !== 3'b000) begin
            failures++; $display("FAIL reset_release_idle got=%b exp=000", {d_dp_valid, d_mem_req, d_busy_out});
        end
        @(negedge clk);
    endtask

    task automatic test_hit();
        logic f;
        exp_fault_q.push_back(1'b0);
        read_valid = 1; tlb_hit = 1; cache_hit = 1; dp_ready = 0;
        #1;
        checks++;
        if ({d_pa_wr_en, d_pa_src, d_read_ready} !== 3'b101) begin
            failures++; $display("FAIL hit_accept got=%b exp=101", {d_pa_wr_en, d_pa_src, d_read_ready});
        end
        @(negedge clk);
        read_valid = 0;
        #1;
        checks++;
        if (d_dp_valid !== 1'b0) begin failures++; $display("FAIL hit_cyc1_dpv got=%b exp=0", d_dp_valid); end
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({d_dp_valid, d_resp_fault} !== 2'b10) begin
                failures++; $display("FAIL hit_hold cyc=%0d got=%b exp=10", c, {d_dp_valid, d_resp_fault});
            end
            @(negedge clk);
        end
        dp_ready = 1;
        #1;
        checks++;
        if (d_dp_valid !== 1'b1 || exp_fault_q.size() == 0) begin
            failures++; $display("FAIL hit_resp dpv=%b exp=1", d_dp_valid);
        end else begin
            f = exp_fault_q.pop_front();
            if (d_resp_fault !== f) begin failures++; $display("FAIL hit_resp_fault got=%b exp=%b", d_resp_fault, f); end
        end
        @(negedge clk);
        dp_ready = 0;
        #1;
        checks++;
        if ({d_read_ready, d_dp_valid} !== 2'b10) begin
            failures++; $display("FAIL hit_back_idle got=%b exp=10", {d_read_ready, d_dp_valid});
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_miss();
        logic [4:0] pat;
        logic [2:0] e;
        logic f;
        int nwr;
        pat = 5'b11101;
        nwr = 0;
        exp_fault_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) exp_wn_q.push_back(3'(i));
        read_valid = 1; tlb_hit = 1; cache_hit = 0;
        @(negedge clk);
        read_valid = 0;
        @(negedge clk);
        bus_grant = 1; bus_busy = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({d_grant_pass, d_req_addr_en} !== 2'b10) begin
                failures++; $display("FAIL miss_pass cyc=%0d got=%b exp=10", c, {d_grant_pass, d_req_addr_en});
            end
            @(negedge clk);
        end
        bus_busy = 0;
        #1;
        checks++;
        if ({d_req_addr_en, d_grant_pass, d_busy_out} !== 3'b100) begin
            failures++; $display("FAIL miss_take got=%b exp=100", {d_req_addr_en, d_grant_pass, d_busy_out});
        end
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            mem_ready = pat[k];
            #1;
            checks++;
            if ({d_busy_out, d_mem_req, d_grant_pass, d_write} !== {3'b110, pat[k]}) begin
                failures++; $display("FAIL miss_fill k=%0d got=%b exp=110%b", k, {d_busy_out, d_mem_req, d_grant_pass, d_write}, pat[k]);
            end
            if (d_write === 1'b1) begin
                nwr++;
                checks++;
                if (exp_wn_q.size() == 0) begin
                    failures++; $display("FAIL miss_wn_extra got=%0d exp=none", d_write_num);
                end else begin
                    e = exp_wn_q.pop_front();
                    if ({1'b0, d_write_num} !== e) begin failures++; $display("FAIL miss_wn got=%0d exp=%0d", d_write_num, e); end
                end
            end
            @(negedge clk);
        end
        mem_ready = 0; dp_ready = 1; bus_grant = 0;
        #1;
        checks++;
        if ({d_busy_out, d_dp_valid} !== 2'b01 || exp_fault_q.size() == 0) begin
            failures++; $display("FAIL miss_resp got=%b exp=01", {d_busy_out, d_dp_valid});
        end else begin
            f = exp_fault_q.pop_front();
            if (d_resp_fault !== f) begin failures++; $display("FAIL miss_resp_fault got=%b exp=%b", d_resp_fault, f); end
        end
        checks++;
        if (nwr != 4) begin failures++; $display("FAIL miss_write_count got=%0d exp=4", nwr); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_fault();
        logic saw_req;
        logic f;
        saw_req = 0;
        exp_fault_q.push_back(1'b1);
        exp_fault_q.push_back(1'b0);
        read_valid = 1; tlb_hit = 0; cache_hit = 0;
        for (int c = 0; c < 2; c++) begin
            #1 saw_req |= d_mem_req;
            @(negedge clk);
            read_valid = 0;
        end
        dp_ready = 1;
        #1 saw_req |= d_mem_req;
        checks++;
        if (d_dp_valid !== 1'b1 || exp_fault_q.size() == 0) begin
            failures++; $display("FAIL fault_resp dpv=%b exp=1", d_dp_valid);
        end else begin
            f = exp_fault_q.pop_front();
            if (d_resp_fault !== f) begin failures++; $display("FAIL fault_flag got=%b exp=%b", d_resp_fault, f); end
        end
        @(negedge clk);
        dp_ready = 0; read_valid = 1; tlb_hit = 1; cache_hit = 1;
        #1 saw_req |= d_mem_req;
        @(negedge clk);
        read_valid = 0;
        @(negedge clk);
        dp_ready = 1;
        #1;
        checks++;
        if (d_dp_valid !== 1'b1 || exp_fault_q.size() == 0) begin
            failures++; $display("FAIL fault_next_resp dpv=%b exp=1", d_dp_valid);
        end else begin
            f = exp_fault_q.pop_front();
            if (d_resp_fault !== f) begin failures++; $display("FAIL fault_next_flag got=%b exp=%b", d_resp_fault, f); end
        end
        checks++;
        if (saw_req !== 1'b0) begin failures++; $display("FAIL fault_mem_req got=%b exp=0", saw_req); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_prefetch();
        logic exp_dpv, exp_rr, exp_wr, f;
        logic [1:0] exp_pa;
        logic [2:0] e;
        reset = 1;
        @(negedge clk);
        reset = 0;
        exp_fault_q.push_back(1'b0);
        for (int i = 0; i < 16; i++) exp_wn_q.push_back(3'(i % 8));
        tlb_hit = 1; cache_hit = 0; bus_grant = 1; bus_busy = 0; mem_ready = 1;
        dp_ready = 1; next_line_hit = 0; next_tlb_hit = 1;
        // demand: accept 0, lookup 1, arb 2, fill 3-10, resp 11; prefetch: pf_addr 12, arb 13, fill 14-21, idle 22
        for (int c = 0; c <= 22; c++) begin
            read_valid = (c == 0) || (c >= 14);
            exp_dpv = (c == 11);
            exp_rr  = (c == 0) || (c == 22);
            exp_wr  = (c >= 3 && c <= 10) || (c >= 14 && c <= 21);
            exp_pa  = (c == 12) ? 2'b11 : ((c == 0 || c == 22) ? 2'b10 : 2'b00);
            #1;
            checks++;
            if ({p_dp_valid, p_read_ready, p_write} !== {exp_dpv, exp_rr, exp_wr}) begin
                failures++; $display("FAIL pf_ctrl cyc=%0d got=%b exp=%b", c, {p_dp_valid, p_read_ready, p_write}, {exp_dpv, exp_rr, exp_wr});
            end
            checks++;
            if ({p_pa_wr_en, p_pa_src} !== exp_pa) begin
                failures++; $display("FAIL pf_pa cyc=%0d got=%b exp=%b", c, {p_pa_wr_en, p_pa_src}, exp_pa);
            end
            if (p_dp_valid === 1'b1) begin
                checks++;
                if (exp_fault_q.size() == 0) begin
                    failures++; $display("FAIL pf_resp_extra cyc=%0d got=1 exp=0", c);
                end else begin
                    f = exp_fault_q.pop_front();
                    if (p_resp_fault !== f) begin failures++; $display("FAIL pf_resp_fault got=%b exp=%b", p_resp_fault, f); end
                end
            end
            if (p_write === 1'b1) begin
                checks++;
                if (exp_wn_q.size() == 0) begin
                    failures++; $display("FAIL pf_wn_extra cyc=%0d got=%0d exp=none", c, p_write_num);
                end else begin
                    e = exp_wn_q.pop_front();
                    if (p_write_num !== e) begin failures++; $display("FAIL pf_wn cyc=%0d got=%0d exp=%0d", c, p_write_num, e); end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_wn_q.size() != 0) begin failures++; $display("FAIL pf_beats_left got=%0d exp=0", exp_wn_q.size()); end
        clear_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        logic [2:0] e;
        logic f;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) exp_wn_q.push_back(3'(i));
            if (pass == 1) exp_fault_q.push_back(1'b0);
            tlb_hit = 1; cache_hit = 0; bus_grant = 1; bus_busy = 0; read_valid = 1;
            @(negedge clk);
            read_valid = 0;
            @(negedge clk);
            @(negedge clk);
            mem_ready = 1;
            for (int b = 0; b < (pass == 0 ? 2 : 4); b++) begin
                #1;
                checks++;
                if (d_write !== 1'b1 || exp_wn_q.size() == 0) begin
                    failures++; $display("FAIL rst_fill_write pass=%0d b=%0d got=%b exp=1", pass, b, d_write);
                end else begin
                    e = exp_wn_q.pop_front();
                    if ({1'b0, d_write_num} !== e) begin failures++; $display("FAIL rst_fill_wn pass=%0d got=%0d exp=%0d", pass, d_write_num, e); end
                end
                @(negedge clk);
            end
            if (pass == 0) begin
                reset = 1;
                #1;
                checks++;
                if (d_outs !== '0) begin failures++; $display("FAIL rst_abort_outs got=%b exp=0", d_outs); end
                exp_wn_q.delete();
                @(negedge clk);
                reset = 0;
                for (int c = 0; c < 3; c++) begin
                    #1;
                    checks++;
                    if ({d_read_ready, d_write, d_mem_req, d_busy_out} !== 4'b1000) begin
                        failures++; $display("FAIL rst_post_idle cyc=%0d got=%b exp=1000", c, {d_read_ready, d_write, d_mem_req, d_busy_out});
                    end
                    @(negedge clk);
                end
                mem_ready = 0;
            end else begin
                mem_ready = 0; dp_ready = 1;
                #1;
                checks++;
                if (d_dp_valid !== 1'b1 || exp_fault_q.size() == 0) begin
                    failures++; $display("FAIL rst_refill_resp dpv=%b exp=1", d_dp_valid);
                end else begin
                    f = exp_fault_q.pop_front();
                    if (d_resp_fault !== f) begin failures++; $display("FAIL rst_refill_fault got=%b exp=%b", d_resp_fault, f); end
                end
                @(negedge clk);
            end
        end
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_hit();
        test_miss();
        test_fault();
        test_prefetch();
        test_reset_mid_fill();
        checks++;
        if (exp_fault_q.size() != 0) begin failures++; $display("FAIL resp_left got=%0d exp=0", exp_fault_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
